// File: rtl/rx_controller.sv
// rx_controller: pairs the serial rate-1/2 coded stream into symbols and decodes it with a
// 64-state hard-decision Viterbi (K=7, 133/171) using register-exchange survivors.
module rx_controller #(
   parameter int D  = 32,
   parameter int MW = 6
) (
   input  logic iClk,
   input  logic iRst_n,
   input  logic iEN,
   input  logic iData,
   output logic oData,
   output logic oValid,
   output logic oBusy
);
   localparam int NW = $clog2(D + 1);
   localparam int IW = $clog2(D);
   localparam logic [MW-1:0] HALF = {1'b1, {(MW-1){1'b0}}};
   localparam logic [MW-1:0] INIT = MW'(16);

   typedef enum logic [1:0] {IDLE, RX, FLUSH} state_t;

   state_t        state_q, state_d;
   logic          sel_q, sel_d, a_q, a_d, pend_q, pend_d;
   logic          odata_q, odata_d, ovalid_q, ovalid_d, obusy_q;
   logic [MW-1:0] pm_q [64], pm_d [64];
   logic [D-1:0]  surv_q [64], surv_d [64];
   logic [NW-1:0] nsym_q, nsym_d;
   logic [IW-1:0] fidx_q, fidx_d;
   logic [5:0]    best_q, best_d, best;
   logic [MW-1:0] acs_pm [64];
   logic [D-1:0]  acs_sv [64];
   logic [63:0]   hi;
   logic          nrm;

   for (genvar n = 0; n < 64; n++) begin : g_acs
      localparam logic [5:0] P0 = 6'(n >> 1);
      localparam logic [5:0] P1 = P0 | 6'd32;
      localparam logic       U  = 1'(n % 2);
      localparam logic [1:0] E0 = {U ^ P0[1] ^ P0[2] ^ P0[4] ^ P0[5], U ^ P0[0] ^ P0[1] ^ P0[2] ^ P0[5]};
      localparam logic [1:0] E1 = {U ^ P1[1] ^ P1[2] ^ P1[4] ^ P1[5], U ^ P1[0] ^ P1[1] ^ P1[2] ^ P1[5]};
      logic [MW:0] c0, c1;
      logic        w;
      assign c0 = {1'b0, pm_q[P0]} + (MW+1)'(a_q ^ E0[1]) + (MW+1)'(iData ^ E0[0]);
      assign c1 = {1'b0, pm_q[P1]} + (MW+1)'(a_q ^ E1[1]) + (MW+1)'(iData ^ E1[0]);
      assign w  = c1 < c0;
      assign acs_pm[n] = w ? c1[MW-1:0] : c0[MW-1:0];
      assign acs_sv[n] = {w ? surv_q[P1][D-2:0] : surv_q[P0][D-2:0], U};
      assign hi[n]     = acs_pm[n] >= HALF;
   end

   assign nrm = &hi;

   // lowest index wins ties because only a strictly smaller metric replaces the candidate
   always_comb begin
      best = '0;
      for (int i = 1; i < 64; i++) best = (pm_q[i] < pm_q[best]) ? 6'(i) : best;
   end

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      a_d      = a_q;
      pend_d   = 1'b0;
      pm_d     = pm_q;
      surv_d   = surv_q;
      nsym_d   = nsym_q;
      best_d   = best_q;
      fidx_d   = fidx_q;
      ovalid_d = pend_q;
      odata_d  = pend_q & surv_q[best][D-1];
      if (iEN && state_q != RX) begin
         state_d = RX;
         sel_d   = 1'b1;
         a_d     = iData;
         nsym_d  = '0;
         for (int i = 0; i < 64; i++) begin
            pm_d[i]   = (i == 0) ? '0 : INIT;
            surv_d[i] = '0;
         end
      end else if (state_q == RX && iEN) begin
         sel_d = ~sel_q;
         a_d   = sel_q ? a_q : iData;
         if (sel_q) begin
            for (int i = 0; i < 64; i++) begin
               pm_d[i]   = acs_pm[i] - (nrm ? HALF : '0);
               surv_d[i] = acs_sv[i];
            end
            nsym_d = (nsym_q == NW'(D)) ? nsym_q : nsym_q + 1'b1;
            pend_d = nsym_d == NW'(D);
         end
      end else if (state_q == RX) begin
         sel_d   = 1'b0;
         best_d  = best;
         fidx_d  = (nsym_q == NW'(D)) ? IW'(D - 2) : IW'(nsym_q - 1'b1);
         state_d = (nsym_q == '0) ? IDLE : FLUSH;
      end else if (state_q == FLUSH) begin
         ovalid_d = 1'b1;
         odata_d  = surv_q[best_q][fidx_q];
         fidx_d   = fidx_q - 1'b1;
         state_d  = (fidx_q == '0) ? IDLE : FLUSH;
      end
   end

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         state_q  <= IDLE;
         sel_q    <= 1'b0;
         a_q      <= 1'b0;
         pend_q   <= 1'b0;
         pm_q     <= '{default: '0};
         surv_q   <= '{default: '0};
         nsym_q   <= '0;
         best_q   <= '0;
         fidx_q   <= '0;
         odata_q  <= 1'b0;
         ovalid_q <= 1'b0;
         obusy_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         a_q      <= a_d;
         pend_q   <= pend_d;
         pm_q     <= pm_d;
         surv_q   <= surv_d;
         nsym_q   <= nsym_d;
         best_q   <= best_d;
         fidx_q   <= fidx_d;
         odata_q  <= odata_d;
         ovalid_q <= ovalid_d;
         obusy_q  <= state_d != IDLE;
      end
   end

   assign oData  = odata_q;
   assign oValid = ovalid_q;
   assign oBusy  = obusy_q;
endmodule

// File: tb/tb_rx_controller.sv
// tb_rx_controller: coded frames driven into rx_controller; decoded bits are compared with the
// source data or with a traceback Viterbi reference built from the trellis rules.
module tb_rx_controller;
   localparam int D = 32;

   logic iClk = 0, iRst_n = 1, iEN = 0, iData = 0;
   logic oData, oValid, oBusy;
   int   checks = 0, failures = 0, cyc = 0;
   int   t_b, t_drop, t_first;
   bit   dq[$], cq[$], exp_q[$], got_q[$];
   int   got_t[$];
   bit   dec [4096][64];
   int   bst [4096];

   rx_controller #(.D(D), .MW(6)) dut (
      .iClk(iClk), .iRst_n(iRst_n), .iEN(iEN), .iData(iData),
      .oData(oData), .oValid(oValid), .oBusy(oBusy)
   );

   always #5 iClk = ~iClk;
   always @(posedge iClk) cyc <= cyc + 1;
   always @(negedge iClk) if (oValid === 1'b1) begin
      got_q.push_back(oData);
      got_t.push_back(cyc);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic bit [1:0] enc_sym(input bit [5:0] s, input bit u);
      return {u ^ s[1] ^ s[2] ^ s[4] ^ s[5], u ^ s[0] ^ s[1] ^ s[2] ^ s[5]};
   endfunction

   task automatic encode();
      bit [5:0] s;
      s = '0;
      cq.delete();
      foreach (dq[i]) begin
         bit [1:0] ab;
         ab = enc_sym(s, dq[i]);
         cq.push_back(ab[1]);
         cq.push_back(ab[0]);
         s = {s[4:0], dq[i]};
      end
   endtask

   task automatic mkdata(input int n, input int tail);
      dq.delete();
      repeat (n) dq.push_back(1'($urandom));
      repeat (tail) dq.push_back(1'b0);
      encode();
   endtask

   function automatic bit trace(input int t, input int back);
      bit [5:0] s;
      s = 6'(bst[t]);
      for (int i = 0; i < back; i++) s = dec[t-i][s] ? {1'b1, s[5:1]} : {1'b0, s[5:1]};
      return s[0];
   endfunction

   // full-history Viterbi: decisions per step, decode by tracing back from the best state
   task automatic model();
      int pm[64], nm[64];
      int k, f, m0, m1;
      exp_q.delete();
      k = cq.size() / 2;
      foreach (pm[n]) pm[n] = (n == 0) ? 0 : 16;
      for (int t = 0; t < k; t++) begin
         bit [1:0] r;
         r = {cq[2*t], cq[2*t+1]};
         for (int n = 0; n < 64; n++) begin
            m0 = pm[n >> 1] + $countones(r ^ enc_sym(6'(n >> 1), n[0]));
            m1 = pm[(n >> 1) + 32] + $countones(r ^ enc_sym(6'((n >> 1) + 32), n[0]));
            dec[t][n] = m1 < m0;
            nm[n] = dec[t][n] ? m1 : m0;
         end
         pm = nm;
         bst[t] = 0;
         for (int n = 1; n < 64; n++) if (pm[n] < pm[bst[t]]) bst[t] = n;
         if (t >= D - 1) exp_q.push_back(trace(t, D - 1));
      end
      f = (k >= D) ? D - 1 : k;
      for (int j = f - 1; j >= 0; j--) exp_q.push_back(trace(k - 1, j));
   endtask

   task automatic send(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge iClk); #2;
         iEN = 1;
         iData = cq[i];
         if (i == 0) t_first = cyc;
         if (i == 2 * D - 1) t_b = cyc;
      end
      @(posedge iClk); #2;
      iEN = 0;
      iData = 0;
      t_drop = cyc;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (oBusy !== 1'b0 && n < 200) begin
         @(negedge iClk);
         n++;
      end
      repeat (3) @(posedge iClk);
      chk("drain", n < 200, 1);
   endtask

   task automatic clr();
      got_q.delete();
      got_t.delete();
   endtask

   function automatic int tat(input int i);
      return (i < got_t.size()) ? got_t[i] : -1;
   endfunction

   task automatic cmp_frame(input string tag, input int from);
      bit g[$];
      foreach (got_q[i]) if (got_t[i] > from) g.push_back(got_q[i]);
      chk({tag, "_n"}, g.size(), exp_q.size());
      foreach (exp_q[i]) if (i < g.size()) chk(tag, g[i], exp_q[i]);
   endtask

   task automatic a5_frame();
      logic [47:0] v;
      v = 48'hA5A5A5A5A5A5;
      dq.delete();
      for (int i = 0; i < 48; i++) dq.push_back(v[i]);
      repeat (6) dq.push_back(1'b0);
      encode();
      exp_q = dq;
   endtask

   initial begin
      int old, n;
      #1 iRst_n = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge iClk); #2;
         iEN = 1'($urandom);
         iData = 1'($urandom);
         @(negedge iClk);
         chk("rst", {oBusy, oValid, oData}, 0);
      end
      @(posedge iClk); #2;
      iEN = 0;
      iData = 0;
      iRst_n = 1;
      repeat (5) begin
         @(negedge iClk);
         chk("idle", {oBusy, oValid, oData}, 0);
      end

      clr();
      a5_frame();
      send(cq.size());
      chk("busy", oBusy, 1);
      drain();
      cmp_frame("a5", -1);
      chk("a5_lat", tat(0), t_b + 2);
      chk("a5_rxgap", tat(22) - tat(0), 44);
      chk("a5_end", tat(53), t_drop + 32);

      clr();
      a5_frame();
      cq[20] = ~cq[20];
      cq[71] = ~cq[71];
      send(cq.size());
      drain();
      cmp_frame("ecc", -1);

      clr();
      dq = '{1, 0, 1, 1, 0, 0, 1, 0, 0, 0};
      encode();
      exp_q = dq;
      send(cq.size());
      drain();
      cmp_frame("short", -1);
      chk("short_t", tat(0), t_drop + 2);
      chk("short_gap", tat(9) - tat(0), 9);

      clr();
      mkdata(20, 0);
      exp_q = dq;
      cq.push_back(1'($urandom));
      send(41);
      drain();
      cmp_frame("odd", -1);

      clr();
      mkdata(40, 0);
      send(80);
      repeat (2) @(posedge iClk);
      mkdata(30, 6);
      exp_q = dq;
      send(cq.size());
      drain();
      cmp_frame("abort", t_first);
      old = 0;
      foreach (got_t[i]) if (got_t[i] <= t_first) old++;
      chk("abort_old", old, 11);

      clr();
      mkdata(48, 6);
      for (int i = 0; i < 80; i++) begin
         @(posedge iClk); #2;
         iEN = 1;
         iData = cq[i];
      end
      @(posedge iClk); #2;
      iRst_n = 0;
      #1 chk("mid_rst", {oBusy, oValid, oData}, 0);
      iEN = 0;
      repeat (3) @(posedge iClk);
      #2 iRst_n = 1;
      clr();
      a5_frame();
      send(cq.size());
      drain();
      cmp_frame("post_rst", -1);

      repeat (4) begin
         clr();
         n = $urandom_range(10, 300);
         mkdata(n, 6);
         foreach (cq[i]) if ($urandom_range(0, 31) == 0) cq[i] = ~cq[i];
         model();
         send(cq.size());
         drain();
         cmp_frame("rnd", -1);
      end

      clr();
      mkdata(1994, 6);
      exp_q = dq;
      send(cq.size());
      drain();
      cmp_frame("long", -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
